execute_muldiv_unit: RTL
========================

Name: execute_muldiv_unit

Overview:
- Parametrised multi-cycle multiply/divide unit for the uDLX execute stage.
- Sits beside the single-cycle ALU and handles MUL/MULH/DIV/REM instructions.
- Uses iterative shift-add multiplication and restoring division, one bit per cycle.
- Stalls the upstream pipeline while busy and delivers a registered result with its destination register address for the EX/MEM pipe.

Parameters:
DATA_WIDTH, 32, operand and result width (even, >=8)
REG_ADDR_WIDTH, 5, destination register address width
OP_WIDTH, 3, muldiv operation code width
CNT_WIDTH, 6, iteration counter width; must satisfy 2^CNT_WIDTH > DATA_WIDTH

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush_in  input  1  abort the in-flight operation, synchronous
start_in  input  1  request a new operation
op_in  input  OP_WIDTH  0 MUL, 1 MULH, 2 MULHU, 3 DIV, 4 DIVU, 5 REM, 6 REMU, 7 reserved
data_a_in  input  DATA_WIDTH  operand A (multiplicand / dividend), already forwarded
data_b_in  input  DATA_WIDTH  operand B (multiplier / divisor), already forwarded
reg_wr_addr_in  input  REG_ADDR_WIDTH  destination register
stall_out  output  1  hold the upstream pipeline
busy_out  output  1  state is not IDLE
done_out  output  1  result valid, single-cycle pulse
result_out  output  DATA_WIDTH  operation result
reg_wr_addr_out  output  REG_ADDR_WIDTH  destination register of the result
div_by_zero_out  output  1  qualifies done_out; DIV/DIVU/REM/REMU had B==0

Behaviour:
- Single clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values:
  - All outputs 0; state IDLE; counter 0; internal accumulators 0.
  - Reset asserted mid-operation discards the operation with no done_out.
- States: IDLE, CALC, DONE.
- IDLE:
  - start_in=1 with op 0..6 latches operands, op and reg_wr_addr, loads counter with DATA_WIDTH and moves to CALC.
  - For signed ops, the magnitudes of the operands are latched and the result sign is recorded.
  - op 7 moves directly to DONE with result 0.
- CALC:
  - Each cycle performs one shift-add or restore-subtract step and decrements the counter.
  - When the counter reaches 1, the step completes and the state moves to DONE.
  - CALC lasts exactly DATA_WIDTH cycles.
- DONE:
  - done_out=1 for exactly one cycle; result_out and reg_wr_addr_out are registered.
  - The state returns to IDLE next cycle.
  - result_out and reg_wr_addr_out hold their values until the next DONE.
- Latency: start sampled at edge N gives done_out high in the cycle after edge N+DATA_WIDTH+1.
- stall_out = (IDLE & start_in) | CALC. It is low in DONE so the pipe advances with the result.
- Any start_in while busy is ignored; the upstream holds it because stall_out is high.
- Multiply:
  - Full 2*DATA_WIDTH product.
  - MUL returns the low half; MULH returns the signed high half; MULHU returns the unsigned high half.
  - Sign correction is a two's-complement negation of the full product.
- Divide:
  - Quotient is truncated toward zero; remainder takes the sign of the dividend.
  - B==0: quotient is all ones, remainder = A, div_by_zero_out=1 with done_out. The full DATA_WIDTH cycles are still taken.
  - Signed overflow (A=MIN, B=-1): quotient = MIN, remainder = 0.
- Flush:
  - flush_in=1 forces IDLE next edge and suppresses done_out.
  - flush_in has priority over start_in in the same cycle.
  - flush_in during DONE clears done_out in that cycle; outputs are not updated.

Optional Feature:
- Macro: MULDIV_SIGNED_EN.
- Defined: MULH, DIV and REM perform signed arithmetic as specified above.
- Undefined:
  - Sign logic is not built.
  - MULH behaves as MULHU, DIV as DIVU, REM as REMU.
  - The signed-overflow rule does not apply.

Test Plan:
- MUL A=7, B=6 → stall_out high for 33 cycles, done_out in cycle 34, result 42, reg_wr_addr echoed.
- MULHU A=0xFFFFFFFF, B=0xFFFFFFFF → result 0xFFFFFFFE; with MULDIV_SIGNED_EN, MULH of the same operands → 0x00000000.
- DIV A=-7, B=2 (macro on) → quotient 0xFFFFFFFD; REM → 0xFFFFFFFF; DIVU A=100, B=7 → 14; REMU → 2.
- DIVU A=5, B=0 → result 0xFFFFFFFF, div_by_zero_out=1; REMU A=5, B=0 → 5; DIV A=0x80000000, B=-1 → 0x80000000.
- start, then flush_in at CALC cycle 10 → IDLE next edge, no done_out; a new start immediately after completes with correct result.
- rst_n low at CALC cycle 5 → all outputs 0 immediately; start_in asserted while busy → ignored, only one done_out.

Source files
------------

// File: rtl/execute_muldiv_unit.sv
// Iterative multiply/divide unit for the uDLX execute stage: shift-add MUL, restoring DIV, one bit per cycle.
// Signed MULH/DIV/REM are built only when MULDIV_SIGNED_EN is defined; otherwise they alias the unsigned ops.
module execute_muldiv_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int OP_WIDTH       = 3,
  parameter int CNT_WIDTH      = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush_in,
  input  logic                      start_in,
  input  logic [OP_WIDTH-1:0]       op_in,
  input  logic [DATA_WIDTH-1:0]     data_a_in,
  input  logic [DATA_WIDTH-1:0]     data_b_in,
  input  logic [REG_ADDR_WIDTH-1:0] reg_wr_addr_in,
  output logic                      stall_out,
  output logic                      busy_out,
  output logic                      done_out,
  output logic [DATA_WIDTH-1:0]     result_out,
  output logic [REG_ADDR_WIDTH-1:0] reg_wr_addr_out,
  output logic                      div_by_zero_out
);

  localparam logic [OP_WIDTH-1:0] OP_MUL   = OP_WIDTH'(0);
  localparam logic [OP_WIDTH-1:0] OP_MULH  = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] OP_MULHU = OP_WIDTH'(2);
  localparam logic [OP_WIDTH-1:0] OP_DIV   = OP_WIDTH'(3);
  localparam logic [OP_WIDTH-1:0] OP_DIVU  = OP_WIDTH'(4);
  localparam logic [OP_WIDTH-1:0] OP_REM   = OP_WIDTH'(5);
  localparam logic [OP_WIDTH-1:0] OP_REMU  = OP_WIDTH'(6);
  localparam logic [OP_WIDTH-1:0] OP_RSVD  = OP_WIDTH'(7);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                    r_state;
  logic [OP_WIDTH-1:0]       r_op;
  logic [REG_ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0]     r_acc;
  logic [DATA_WIDTH-1:0]     r_mq;
  logic [DATA_WIDTH-1:0]     r_b;
  logic                      r_b_zero;
  logic [CNT_WIDTH-1:0]      r_cnt;
  logic                      r_done;
  logic                      r_dbz;
  logic [DATA_WIDTH-1:0]     r_result;
  logic [REG_ADDR_WIDTH-1:0] r_addr_out;

  logic                      w_in_is_mul;
  logic                      w_r_is_div;
  logic                      w_accept;
  logic [DATA_WIDTH-1:0]     w_a_mag;
  logic [DATA_WIDTH-1:0]     w_b_mag;
  logic [DATA_WIDTH:0]       w_add;
  logic [DATA_WIDTH:0]       w_mul_sum;
  logic [DATA_WIDTH:0]       w_shift;
  logic [DATA_WIDTH:0]       w_diff;
  logic                      w_div_ok;
  logic [2*DATA_WIDTH-1:0]   w_prod;
  logic [2*DATA_WIDTH-1:0]   w_prod_fix;
  logic [DATA_WIDTH-1:0]     w_quo_fix;
  logic [DATA_WIDTH-1:0]     w_rem_fix;
  logic [DATA_WIDTH-1:0]     w_result;

  assign w_in_is_mul = (op_in == OP_MUL) | (op_in == OP_MULH) | (op_in == OP_MULHU);
  assign w_r_is_div  = (r_op >= OP_DIV) & (r_op <= OP_REMU);
  assign w_accept    = (r_state == S_IDLE) & start_in & ~flush_in;

  assign stall_out       = ((r_state == S_IDLE) & start_in) | (r_state == S_CALC);
  assign busy_out        = (r_state != S_IDLE);
  assign done_out        = r_done;
  assign result_out      = r_result;
  assign reg_wr_addr_out = r_addr_out;
  assign div_by_zero_out = r_dbz;

`ifdef MULDIV_SIGNED_EN
  logic w_signed_op;
  logic w_a_neg;
  logic w_b_neg;
  logic r_neg_q;
  logic r_neg_r;

  assign w_signed_op = (op_in == OP_MULH) | (op_in == OP_DIV) | (op_in == OP_REM);
  assign w_a_neg     = w_signed_op & data_a_in[DATA_WIDTH-1];
  assign w_b_neg     = w_signed_op & data_b_in[DATA_WIDTH-1];
  assign w_a_mag     = w_a_neg ? -data_a_in : data_a_in;
  assign w_b_mag     = w_b_neg ? -data_b_in : data_b_in;

  // Product/quotient sign is the XOR of operand signs; remainder follows the dividend.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_accept) begin
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
    end
  end

  assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
  assign w_quo_fix  = r_neg_q ? -r_mq : r_mq;
  assign w_rem_fix  = r_neg_r ? -r_acc : r_acc;
`else
  assign w_a_mag    = data_a_in;
  assign w_b_mag    = data_b_in;
  assign w_prod_fix = w_prod;
  assign w_quo_fix  = r_mq;
  assign w_rem_fix  = r_acc;
`endif

  // Multiply: {acc, mq} shifts right, adding the multiplicand when the multiplier LSB is set.
  assign w_add     = {1'b0, r_acc} + {1'b0, r_b};
  assign w_mul_sum = r_mq[0] ? w_add : {1'b0, r_acc};

  // Divide: shift the next dividend bit into the partial remainder and try a subtract.
  assign w_shift  = {r_acc, r_mq[DATA_WIDTH-1]};
  assign w_diff   = w_shift - {1'b0, r_b};
  assign w_div_ok = ~w_diff[DATA_WIDTH];

  assign w_prod = {r_acc, r_mq};

  always_comb begin
    w_result = '0;
    case (r_op)
      OP_MUL:           w_result = w_prod_fix[DATA_WIDTH-1:0];
      OP_MULH,
      OP_MULHU:         w_result = w_prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
      OP_DIV, OP_DIVU:  w_result = r_b_zero ? '1 : w_quo_fix;
      OP_REM, OP_REMU:  w_result = w_rem_fix;
      default:          w_result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_op       <= '0;
      r_addr     <= '0;
      r_acc      <= '0;
      r_mq       <= '0;
      r_b        <= '0;
      r_b_zero   <= 1'b0;
      r_cnt      <= '0;
      r_done     <= 1'b0;
      r_dbz      <= 1'b0;
      r_result   <= '0;
      r_addr_out <= '0;
    end else begin
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      if (flush_in) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start_in) begin
              r_op     <= op_in;
              r_addr   <= reg_wr_addr_in;
              r_acc    <= '0;
              r_mq     <= w_in_is_mul ? w_b_mag : w_a_mag;
              r_b      <= w_in_is_mul ? w_a_mag : w_b_mag;
              r_b_zero <= (data_b_in == '0);
              if (op_in == OP_RSVD) begin
                r_state <= S_DONE;
                r_cnt   <= '0;
              end else begin
                r_state <= S_CALC;
                r_cnt   <= CNT_WIDTH'(DATA_WIDTH);
              end
            end
          end
          S_CALC: begin
            if (w_r_is_div) begin
              r_acc <= w_div_ok ? w_diff[DATA_WIDTH-1:0] : w_shift[DATA_WIDTH-1:0];
              r_mq  <= {r_mq[DATA_WIDTH-2:0], w_div_ok};
            end else begin
              r_acc <= w_mul_sum[DATA_WIDTH:1];
              r_mq  <= {w_mul_sum[0], r_mq[DATA_WIDTH-1:1]};
            end
            r_cnt <= r_cnt - CNT_WIDTH'(1);
            if (r_cnt == CNT_WIDTH'(1)) r_state <= S_DONE;
          end
          S_DONE: begin
            r_result   <= w_result;
            r_addr_out <= r_addr;
            r_done     <= 1'b1;
            r_dbz      <= w_r_is_div & r_b_zero;
            r_state    <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
